multiword_add_seq: RTL and testbench
====================================

Name: multiword_add_seq

Overview:
- Sequential multi-word adder. Adds two wide operands one SLICE_WIDTH-bit slice per cycle, LSB slice first.
- The carry is held in a register and fed into the next slice's carry-in.
- Sits upstream of datapath consumers that need wide sums, carry and signed overflow. Trades latency for a narrow carry chain.
- Transactions in and out use valid/ready handshakes.

Parameters:
- SLICE_WIDTH, 16: width of one addition slice.
- NUM_SLICES, 4: number of slices per operand (must be >= 1).
- TOTAL_WIDTH, SLICE_WIDTH*NUM_SLICES: derived operand width; do not override.

Ports:
- clk  input  1  single clock for all state.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operands and carry_in present.
- in_ready  output  1  block can accept operands.
- in0  input  TOTAL_WIDTH  operand A.
- in1  input  TOTAL_WIDTH  operand B.
- carry_in  input  1  carry into slice 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  TOTAL_WIDTH  result modulo 2^TOTAL_WIDTH.
- carry_out  output  1  carry out of the top slice.
- overflow  output  1  two's-complement overflow of the full-width add.
- busy  output  1  high in ADD or DONE.

Behaviour:
- Reset (async, rst_n low), effective immediately:
  - state=IDLE; operand regs, slice index, carry reg, sum, carry_out, overflow = 0.
  - out_valid=0, busy=0, in_ready=1.
- FSM states: IDLE, ADD, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE:
  - On in_valid&&in_ready: capture in0, in1; carry reg<=carry_in; idx<=0; -> ADD.
  - sum/carry_out/overflow keep their previous values.
- ADD, each cycle:
  - {c, s} = in0_slice[idx] + in1_slice[idx] + carry_reg, computed at SLICE_WIDTH+1 bits, zero-extended.
  - sum slice idx <= s; carry_reg <= c; idx <= idx+1.
- ADD, when idx==NUM_SLICES-1:
  - carry_out <= c.
  - overflow <= (in0[MSB]==in1[MSB]) && (s[SLICE_WIDTH-1]!=in0[MSB]), with MSB = TOTAL_WIDTH-1. carry_in is included in the sum.
  - -> DONE.
- DONE:
  - Hold sum, carry_out, overflow stable.
  - On out_ready: -> IDLE.
  - in_valid is ignored (in_ready=0).
- Latency: out_valid rises exactly NUM_SLICES cycles after the accepting edge.
- Minimum spacing between accepts: NUM_SLICES+2 cycles. No overlap between transactions.
- NUM_SLICES=1: a single ADD cycle, and idx stays 0.
- idx width: $clog2(NUM_SLICES), minimum 1 bit. It never wraps past NUM_SLICES-1.
- sum is only meaningful while out_valid=1. Partial slices are visible during ADD; the consumer must not sample them.
- Reset mid-ADD or mid-DONE aborts the transaction with no output handshake.
- Stable operands are not required after acceptance; the captured copies are used.

Decomposition:
- Package multiword_add_pkg holds:
  - the state_t enum (IDLE, ADD, DONE);
  - a slice_sum_t struct {logic carry; logic [SLICE_WIDTH-1:0] s} only if the package is parameter-free; otherwise keep it local.
- One sub-module, slice_add:
  - combinational SLICE_WIDTH-bit adder with carry_in and carry_out;
  - instantiated once and muxed by idx.

Test Plan:
- Wrap to zero: 0x0000_0000_0000_0001 + 0xFFFF_FFFF_FFFF_FFFF, cin=0 -> sum=0, carry_out=1, overflow=0. out_valid exactly 4 cycles after the accept edge.
- Carry propagation: 0x0000_FFFF_FFFF_FFFF + 0, cin=1 -> sum=0x0001_0000_0000_0000, carry_out=0, overflow=0.
- Signed overflow, positive: 0x7FFF_FFFF_FFFF_FFFF + 0x1 -> sum=0x8000_0000_0000_0000, overflow=1, carry_out=0.
- Signed overflow, negative: 0x8000_0000_0000_0000 + 0x8000_0000_0000_0000 -> sum=0, carry_out=1, overflow=1.
- Backpressure: out_ready=0 for 5 cycles with in_valid held high -> out_valid=1, sum/flags stable, in_ready=0. Release out_ready -> IDLE next cycle; the held input is accepted the following edge.
- Reset mid-operation: rst_n low during the 3rd ADD cycle -> same cycle out_valid=0, sum=0, busy=0, in_ready=1. After release, a new add of 5+7 returns sum=12 normally.

Source files
------------

// File: rtl/multiword_add_pkg.sv
// Shared types for the sequential multi-word adder.
// Only parameter-free definitions live here.
package multiword_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/slice_add.sv
// One combinational slice of the multi-word adder.
// Produces the slice sum plus its carry out.
module slice_add
  import multiword_add_pkg::*;
#(
  parameter int SLICE_WIDTH = 16
) (
  input  logic [SLICE_WIDTH-1:0] a,
  input  logic [SLICE_WIDTH-1:0] b,
  input  logic                   cin,
  output logic [SLICE_WIDTH-1:0] s,
  output logic                   cout
);

  typedef struct packed {
    logic                   carry;
    logic [SLICE_WIDTH-1:0] s;
  } slice_sum_t;

  slice_sum_t r;

  assign r = {1'b0, a} + {1'b0, b}
           + {{SLICE_WIDTH{1'b0}}, cin};

  assign s    = r.s;
  assign cout = r.carry;

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential wide adder: one slice per cycle, LSB first,
// carry held in a register between slices.
module multiword_add_seq
  import multiword_add_pkg::*;
#(
  parameter int SLICE_WIDTH = 16,
  parameter int NUM_SLICES  = 4,
  parameter int TOTAL_WIDTH = SLICE_WIDTH * NUM_SLICES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TOTAL_WIDTH-1:0] in0,
  input  logic [TOTAL_WIDTH-1:0] in1,
  input  logic                   carry_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TOTAL_WIDTH-1:0] sum,
  output logic                   carry_out,
  output logic                   overflow,
  output logic                   busy
);

  localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int MSB   = TOTAL_WIDTH - 1;

  state_t                 state;
  logic [TOTAL_WIDTH-1:0] a_q;
  logic [TOTAL_WIDTH-1:0] b_q;
  logic [IDX_W-1:0]       idx;
  logic                   carry_q;
  logic [TOTAL_WIDTH-1:0] sum_q;
  logic                   cout_q;
  logic                   ovf_q;

  logic [SLICE_WIDTH-1:0] a_sl;
  logic [SLICE_WIDTH-1:0] b_sl;
  logic [SLICE_WIDTH-1:0] s;
  logic                   c;
  logic                   last;

  assign a_sl = a_q[int'(idx)*SLICE_WIDTH +: SLICE_WIDTH];
  assign b_sl = b_q[int'(idx)*SLICE_WIDTH +: SLICE_WIDTH];
  assign last = (idx == IDX_W'(NUM_SLICES - 1));

  slice_add #(
    .SLICE_WIDTH(SLICE_WIDTH)
  ) u_slice (
    .a   (a_sl),
    .b   (b_sl),
    .cin (carry_q),
    .s   (s),
    .cout(c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in0;
            b_q     <= in1;
            carry_q <= carry_in;
            idx     <= '0;
            state   <= ADD;
          end
        end
        ADD: begin
          sum_q[int'(idx)*SLICE_WIDTH +: SLICE_WIDTH] <= s;
          carry_q <= c;
          if (last) begin
            cout_q <= c;
            // top slice sign vs. operand signs
            ovf_q  <= (a_q[MSB] == b_q[MSB])
                   && (s[SLICE_WIDTH-1] != a_q[MSB]);
            state  <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Scoreboard bench for multiword_add_seq.
// Directed vectors, expectations queued at accept.
module tb_multiword_add_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in0 = '0;
  logic [63:0] in1 = '0;
  logic        carry_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] sum;
  logic        carry_out;
  logic        overflow;
  logic        busy;

  typedef struct {
    logic [63:0] sum;
    logic        c;
    logic        o;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   seen = 0;

  multiword_add_seq #(
    .SLICE_WIDTH(16),
    .NUM_SLICES (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in0      (in0),
    .in1      (in1),
    .carry_in (carry_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry_out(carry_out),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: latency on first sight, compare on handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !seen) begin
        seen = 1;
        if (q.size() > 0)
          chk("latency", 64'(cyc - q[0].acc), 64'd4);
        else
          chk("unexpected_out", 64'd1, 64'd0);
      end
      if (!out_valid) seen = 0;
      if (out_valid && out_ready && q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("sum", sum, e.sum);
        chk("carry_out", 64'(carry_out), 64'(e.c));
        chk("overflow", 64'(overflow), 64'(e.o));
      end
    end else begin
      seen = 0;
    end
  end

  task automatic send(logic [63:0] a, logic [63:0] b,
                      logic ci, logic [63:0] es,
                      logic ec, logic eo);
    int n;
    exp_t e;
    @(posedge clk); #2;
    in0 = a; in1 = b; carry_in = ci; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (!in_ready) chk("accept_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    e.sum = es; e.c = ec; e.o = eo; e.acc = cyc;
    q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() > 0 || busy) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0 || busy)
      chk("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    exp_t e;
    int n;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", sum, 64'd0);
    chk("rst_flags", {62'd0, carry_out, overflow}, 64'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    send(64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
         64'h0, 1'b1, 1'b0);
    send(64'h0000_FFFF_FFFF_FFFF, 64'h0, 1'b1,
         64'h0001_0000_0000_0000, 1'b0, 1'b0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
         64'h8000_0000_0000_0000, 1'b0, 1'b1);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
         1'b0, 64'h0, 1'b1, 1'b1);
    send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111,
         1'b0, 64'h2345_6789_ABCD_F001, 1'b0, 1'b0);
    drain();

    // backpressure with next request held on the input
    @(posedge clk); #2;
    out_ready = 1'b0;
    in0 = 64'd3; in1 = 64'd4; carry_in = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    e.sum = 64'd7; e.c = 1'b0; e.o = 1'b0; e.acc = cyc;
    q.push_back(e);
    in0 = 64'd10; in1 = 64'd20;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    if (!out_valid) chk("bp_timeout", 64'd1, 64'd0);
    repeat (5) begin
      @(posedge clk); #2;
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_sum", sum, 64'd7);
      chk("bp_flags", {62'd0, carry_out, overflow}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    chk("bp_idle_in_ready", 64'(in_ready), 64'd1);
    chk("bp_idle_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("bp_held_accept", 64'(busy), 64'd1);
    e.sum = 64'd30; e.c = 1'b0; e.o = 1'b0; e.acc = cyc;
    q.push_back(e);
    in_valid = 1'b0;
    drain();

    // reset during the third ADD cycle
    send(64'hFFFF_0001_0002, 64'h1_0003_0004, 1'b0,
         64'h1_0000_0004_0006, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_sum", sum, 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    void'(q.pop_back());
    @(posedge clk); #2;
    rst_n = 1'b1;
    send(64'd5, 64'd7, 1'b0, 64'd12, 1'b0, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
